// File: rtl/render_pkg.sv
// Shared types and constants for the pixel rendering stage: FSM states,
// command op codes and frame coordinate field widths.
package render_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_DRAW,
        ST_CLEAR,
        ST_DONE
    } render_state_t;

    localparam logic [2:0] OP_CLEAR = 3'b000;
    localparam logic [2:0] OP_DRAW  = 3'b110;
    localparam logic [2:0] OP_FLIP  = 3'b111;

    localparam int X_W = 9;
    localparam int Y_W = 8;

endpackage

// File: rtl/render_engine_line_stepper.sv
// Bresenham line walker: load captures endpoints and derives dx/dy/err,
// each step advances one pixel toward the end point.
module line_stepper
    import render_pkg::*;
(
    input  logic           clk,
    input  logic           load,
    input  logic           step,
    input  logic [X_W-1:0] x0,
    input  logic [Y_W-1:0] y0,
    input  logic [X_W-1:0] x1,
    input  logic [Y_W-1:0] y1,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last
);

    logic [X_W-1:0]     x_p0, x1_p0, x_nxt;
    logic [Y_W-1:0]     y_p0, y1_p0, y_nxt;
    logic signed [10:0] dx_p0, dy_p0, err_p0, err_nxt;
    logic signed [10:0] ddx, ddy, adx, ady;
    logic signed [11:0] e2, dx_w, dy_w;
    logic               sx_neg_p0, sy_neg_p0;

    always_comb begin
        ddx     = signed'(11'(x1)) - signed'(11'(x0));
        ddy     = signed'(11'(y1)) - signed'(11'(y0));
        adx     = (ddx < 0) ? -ddx : ddx;
        ady     = (ddy < 0) ? -ddy : ddy;
        e2      = {err_p0, 1'b0};
        dx_w    = dx_p0;
        dy_w    = dy_p0;
        err_nxt = err_p0;
        x_nxt   = x_p0;
        y_nxt   = y_p0;
        // Both tests use the pre-step e2, so a diagonal move applies both.
        if (e2 >= dy_w) begin
            err_nxt = err_nxt + dy_p0;
            x_nxt   = sx_neg_p0 ? x_p0 - 1'b1 : x_p0 + 1'b1;
        end
        if (e2 <= dx_w) begin
            err_nxt = err_nxt + dx_p0;
            y_nxt   = sy_neg_p0 ? y_p0 - 1'b1 : y_p0 + 1'b1;
        end
    end

    // stage p0: walker registers
    always_ff @(posedge clk) begin
        if (load) begin
            x_p0      <= x0;
            y_p0      <= y0;
            x1_p0     <= x1;
            y1_p0     <= y1;
            dx_p0     <= adx;
            dy_p0     <= -ady;
            err_p0    <= adx - ady;
            sx_neg_p0 <= (ddx < 0);
            sy_neg_p0 <= (ddy < 0);
        end else if (step) begin
            x_p0   <= x_nxt;
            y_p0   <= y_nxt;
            err_p0 <= err_nxt;
        end
    end

    assign x    = x_p0;
    assign y    = y_p0;
    assign last = (x_p0 == x1_p0) && (y_p0 == y1_p0);

endmodule

// File: rtl/render_engine.sv
// Pixel rendering stage: draws lines / clears the back buffer and owns
// front/back buffer selection. Optional clipping via RENDER_CLIP_EN.
module render_engine
    import render_pkg::*;
#(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int ADDR_W = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               received_op,
    input  logic               flip_buffer,
    input  logic [2:0]         op,
    input  logic [16:0]        start,
    input  logic [16:0]        end1,
    input  logic [23:0]        color,
    input  logic               wr_ready,
    output logic               render_enable,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [23:0]        wr_data,
    output logic               buf_sel
);

    localparam logic [ADDR_W-1:0] FRAME_WORDS = ADDR_W'(WIDTH * HEIGHT);
    localparam logic [ADDR_W-1:0] ROW_WORDS   = ADDR_W'(WIDTH);

    render_state_t      state, state_nxt;
    logic [16:0]        start_p0, end_p0;
    logic [23:0]        color_p0;
    logic               is_draw_p0;
    logic [ADDR_W-1:0]  clr_addr_p0, clr_end_p0;
    logic               buf_sel_q, flip_pend;
    logic               accept, load, step, last, clipped;
    logic [X_W-1:0]     px;
    logic [Y_W-1:0]     py;
    logic [ADDR_W-1:0]  back_base, draw_addr;

    line_stepper u_stepper (
        .clk  (clk),
        .load (load),
        .step (step),
        .x0   (start_p0[X_W+Y_W-1:Y_W]),
        .y0   (start_p0[Y_W-1:0]),
        .x1   (end_p0[X_W+Y_W-1:Y_W]),
        .y1   (end_p0[Y_W-1:0]),
        .x    (px),
        .y    (py),
        .last (last)
    );

    assign accept    = (state == ST_IDLE) && received_op && (op == OP_DRAW || op == OP_CLEAR);
    assign back_base = buf_sel_q ? '0 : FRAME_WORDS;
    assign draw_addr = back_base + ADDR_W'(py) * ROW_WORDS + ADDR_W'(px);

`ifdef RENDER_CLIP_EN
    assign clipped = (32'(px) >= WIDTH) || (32'(py) >= HEIGHT);
`else
    assign clipped = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_SETUP;
            ST_SETUP: begin
                load      = 1'b1;
                state_nxt = is_draw_p0 ? ST_DRAW : ST_CLEAR;
            end
            ST_DRAW: begin
                wr_en   = !clipped;
                wr_addr = draw_addr;
                // A clipped pixel completes its step without a write.
                if (clipped || wr_ready) begin
                    if (last) state_nxt = ST_DONE;
                    else      step      = 1'b1;
                end
            end
            ST_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = clr_addr_p0;
                if (wr_ready && clr_addr_p0 == clr_end_p0) state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // stage p0: command latch and clear address counter
    always_ff @(posedge clk) begin
        if (accept) begin
            start_p0   <= start;
            end_p0     <= end1;
            is_draw_p0 <= (op == OP_DRAW);
        end
        if (state == ST_SETUP) begin
            clr_addr_p0 <= back_base;
            clr_end_p0  <= back_base + FRAME_WORDS - 1'b1;
        end else if (state == ST_CLEAR && wr_ready) begin
            clr_addr_p0 <= clr_addr_p0 + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_sel_q <= 1'b0;
            flip_pend <= 1'b0;
            color_p0  <= '0;
        end else begin
            if (accept) color_p0 <= color;
            // Flips requested while busy collapse into one, applied on DONE->IDLE.
            if (state == ST_IDLE) begin
                if (flip_buffer) buf_sel_q <= ~buf_sel_q;
            end else if (state == ST_DONE) begin
                if (flip_pend || flip_buffer) buf_sel_q <= ~buf_sel_q;
                flip_pend <= 1'b0;
            end else if (flip_buffer) begin
                flip_pend <= 1'b1;
            end
        end
    end

    assign render_enable = (state != ST_IDLE);
    assign wr_data       = color_p0;
    assign buf_sel       = buf_sel_q;

endmodule
